// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: owns NUM_SPRITES sprite positions for the draw controller.
// Sprite 0 follows the buttons and clamps at the bounds. Sprites 1..N-1 move on
// their own. A respawn request places every sprite at an LFSR-random position,
// one sprite per cycle. Motion is paced by an internal game-tick enable.
// Build option: define SPRITE_WRAP_EN to make autonomous sprites wrap around
// the play field instead of bouncing off its edges.
// Parameters must satisfy X_MIN + 64*(NUM_SPRITES-1) <= X_MAX and COORD_W <= 16.
`timescale 1ns/1ps
module sprite_motion_ctrl #(
  parameter int NUM_SPRITES = 2,
  parameter int COORD_W     = 11,
  parameter int STEP        = 2,
  parameter int X_MIN       = 10,
  parameter int X_MAX       = 1380,
  parameter int Y_MIN       = 10,
  parameter int Y_MAX       = 840,
  parameter int TICK_DIV    = 3333334
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [4:0]                     btn,
  output logic [NUM_SPRITES*COORD_W-1:0] pos_x,
  output logic [NUM_SPRITES*COORD_W-1:0] pos_y,
  output logic                           game_tick,
  output logic                           spawn_busy,
  output logic                           spawn_done
);

  localparam int CW1 = COORD_W + 1;
  localparam int TW  = $clog2(TICK_DIV);
  localparam int IW  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  localparam logic [CW1-1:0] XMN = CW1'(X_MIN);
  localparam logic [CW1-1:0] XMX = CW1'(X_MAX);
  localparam logic [CW1-1:0] YMN = CW1'(Y_MIN);
  localparam logic [CW1-1:0] YMX = CW1'(Y_MAX);
  localparam logic [CW1-1:0] STP = CW1'(STEP);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(NUM_SPRITES - 1);

  typedef enum logic [1:0] {S_RUN, S_SPAWN, S_DONE} state_t;

  state_t               state;
  logic [IW-1:0]        idx;
  logic [TW-1:0]        tick_cnt;
  logic [4:0]           btn_p0, btn_p1;
  logic                 btn0_d, spawn_req;
  logic [15:0]          lx [NUM_SPRITES];
  logic [15:0]          ly [NUM_SPRITES];
  logic [COORD_W-1:0]   px [NUM_SPRITES];
  logic [COORD_W-1:0]   py [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] dxf, dyf;
  logic [COORD_W:0]     ax [NUM_SPRITES];
  logic [COORD_W:0]     ay [NUM_SPRITES];
  logic [COORD_W-1:0]   s0_x, s0_y;

  function automatic logic [15:0] nz(input logic [15:0] s);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  function automatic logic [15:0] seed_x(input int i);
    logic [31:0] m;
    m = i * 32'h1F35;
    return nz(16'hACE1 ^ m[15:0]);
  endfunction

  function automatic logic [15:0] seed_y(input int i);
    logic [31:0] m;
    m = i * 32'h2B47;
    return nz(16'hBEEF ^ m[15:0]);
  endfunction

  // Fold the LFSR offset into [0, mx-mn]: one subtraction, then saturate.
  function automatic logic [COORD_W-1:0] rand_pos(input logic [15:0] l,
                                                  input logic [CW1-1:0] mn,
                                                  input logic [CW1-1:0] mx);
    logic [CW1-1:0] off, r, s;
    off = {1'b0, l[COORD_W-1:0]};
    r   = mx - mn;
    if (off > r) off = off - (r + 1'b1);
    if (off > r) off = r;
    s = mn + off;
    return s[COORD_W-1:0];
  endfunction

  function automatic logic [CW1-1:0] dec_sat(input logic [CW1-1:0] p, input logic [CW1-1:0] mn);
    return (p < mn + STP) ? mn : p - STP;
  endfunction

  function automatic logic [CW1-1:0] inc_sat(input logic [CW1-1:0] p, input logic [CW1-1:0] mx);
    return (p + STP > mx) ? mx : p + STP;
  endfunction

  // Button-driven axis move; an opposing pair held together cancels.
  function automatic logic [COORD_W-1:0] move0(input logic [COORD_W-1:0] p, input logic dn,
                                               input logic up, input logic [CW1-1:0] mn,
                                               input logic [CW1-1:0] mx);
    logic [CW1-1:0] q;
    q = {1'b0, p};
    if (dn && !up)      q = dec_sat(q, mn);
    else if (up && !dn) q = inc_sat(q, mx);
    return q[COORD_W-1:0];
  endfunction

  // Autonomous axis move; returns {new direction, new position}.
  function automatic logic [COORD_W:0] step_auto(input logic [COORD_W-1:0] p, input logic d,
                                                 input logic [CW1-1:0] mn,
                                                 input logic [CW1-1:0] mx);
    logic [CW1-1:0] q;
    logic           nd;
    nd = d;
    q  = {1'b0, p};
    if (d) begin
      if (q + STP > mx) begin
`ifdef SPRITE_WRAP_EN
        q = mn;
`else
        q  = mx;
        nd = 1'b0;
`endif
      end else begin
        q = q + STP;
      end
    end else begin
      if (q < mn + STP) begin
`ifdef SPRITE_WRAP_EN
        q = mx;
`else
        q  = mn;
        nd = 1'b1;
`endif
      end else begin
        q = q - STP;
      end
    end
    return {nd, q[COORD_W-1:0]};
  endfunction

  assign game_tick = (tick_cnt == TICK_LAST);

  // Button synchroniser and registered respawn rising-edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_p0    <= '0;
      btn_p1    <= '0;
      btn0_d    <= 1'b0;
      spawn_req <= 1'b0;
    end else begin
      btn_p0    <= btn;
      btn_p1    <= btn_p0;
      btn0_d    <= btn_p1[0];
      spawn_req <= btn_p1[0] & ~btn0_d;
    end
  end

  // Game-tick divider, free running regardless of FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
    else                           tick_cnt <= tick_cnt + 1'b1;
  end

  // Per-sprite LFSR pairs, shifting every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        lx[i] <= seed_x(i);
        ly[i] <= seed_y(i);
      end
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        lx[i] <= {lx[i][14:0], lx[i][15] ^ lx[i][13] ^ lx[i][12] ^ lx[i][10]};
        ly[i] <= {ly[i][14:0], ly[i][15] ^ ly[i][14] ^ ly[i][13] ^ ly[i][11]};
      end
    end
  end

  // Next-tick candidates for every sprite.
  always_comb begin
    s0_x = move0(px[0], btn_p1[2], btn_p1[3], XMN, XMX);
    s0_y = move0(py[0], btn_p1[1], btn_p1[4], YMN, YMX);
    for (int i = 0; i < NUM_SPRITES; i++) begin
      ax[i] = step_auto(px[i], dxf[i], XMN, XMX);
      ay[i] = step_auto(py[i], dyf[i], YMN, YMX);
    end
  end

  // Run/respawn FSM together with the position and direction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RUN;
      idx        <= '0;
      spawn_busy <= 1'b0;
      spawn_done <= 1'b0;
      dxf        <= '1;
      dyf        <= '1;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        px[i] <= COORD_W'(X_MIN + 64 * i);
        py[i] <= COORD_W'(Y_MIN);
      end
    end else begin
      spawn_done <= 1'b0;
      case (state)
        S_RUN: begin
          if (game_tick) begin
            px[0] <= s0_x;
            py[0] <= s0_y;
            for (int i = 1; i < NUM_SPRITES; i++) begin
              {dxf[i], px[i]} <= ax[i];
              {dyf[i], py[i]} <= ay[i];
            end
          end
          if (spawn_req) begin
            state      <= S_SPAWN;
            idx        <= '0;
            spawn_busy <= 1'b1;
          end
        end
        S_SPAWN: begin
          px[idx] <= rand_pos(lx[idx], XMN, XMX);
          py[idx] <= rand_pos(ly[idx], YMN, YMX);
          if (idx == IDX_LAST) begin
            state      <= S_DONE;
            spawn_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          state      <= S_RUN;
          spawn_busy <= 1'b0;
        end
        default: begin
          state      <= S_RUN;
          spawn_busy <= 1'b0;
        end
      endcase
    end
  end

  // Pack sprite registers onto the flat output buses.
  always_comb begin
    pos_x = '0;
    pos_y = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      pos_x[i*COORD_W +: COORD_W] = px[i];
      pos_y[i*COORD_W +: COORD_W] = py[i];
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed testbench for sprite_motion_ctrl with two sprites and a 4-clock tick.
`timescale 1ns/1ps
module tb_sprite_motion_ctrl;

  localparam int NS = 2;
  localparam int CW = 11;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [4:0]     btn = 5'b0;
  logic [NS*CW-1:0] pos_x, pos_y;
  logic           game_tick, spawn_busy, spawn_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mlx [NS];
  logic [15:0] mly [NS];

  sprite_motion_ctrl #(
    .NUM_SPRITES(NS), .COORD_W(CW), .STEP(2),
    .X_MIN(10), .X_MAX(1380), .Y_MIN(10), .Y_MAX(840), .TICK_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .pos_x(pos_x), .pos_y(pos_y),
    .game_tick(game_tick), .spawn_busy(spawn_busy), .spawn_done(spawn_done)
  );

  always #5 clk = ~clk;

  // Reference LFSRs with hand-derived seeds for sprites 0 and 1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mlx[0] <= 16'hACE1; mly[0] <= 16'hBEEF;
      mlx[1] <= 16'hB3D4; mly[1] <= 16'h95A8;
    end else begin
      for (int i = 0; i < NS; i++) begin
        mlx[i] <= {mlx[i][14:0], mlx[i][15] ^ mlx[i][13] ^ mlx[i][12] ^ mlx[i][10]};
        mly[i] <= {mly[i][14:0], mly[i][15] ^ mly[i][14] ^ mly[i][13] ^ mly[i][11]};
      end
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sx(input int i);
    return int'(pos_x[i*CW +: CW]);
  endfunction

  function automatic int sy(input int i);
    return int'(pos_y[i*CW +: CW]);
  endfunction

  function automatic int rpos(input logic [15:0] l, input int mn, input int mx);
    int off, r;
    off = int'(l[10:0]);
    r   = mx - mn;
    if (off > r) off = off - (r + 1);
    if (off > r) off = r;
    return mn + off;
  endfunction

  // Wait for n game ticks, then one more falling edge so the move is visible.
  task automatic wait_ticks(input int n);
    int seen, cyc;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < n * 8 + 16) begin
      @(negedge clk);
      cyc++;
      if (game_tick) seen++;
    end
    if (seen < n) check_eq("tick_timeout", seen, n);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_s0x"}, sx(0), 10);
    check_eq({tag, "_s1x"}, sx(1), 74);
    check_eq({tag, "_s0y"}, sy(0), 10);
    check_eq({tag, "_s1y"}, sy(1), 10);
    check_eq({tag, "_tick"}, int'(game_tick), 0);
    check_eq({tag, "_busy"}, int'(spawn_busy), 0);
    check_eq({tag, "_done"}, int'(spawn_done), 0);
  endtask

  initial begin
    int c, e0x, e0y, e1x, e1y, nb, nd;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_vals("rst");

    // Diagonal x+/y+ from reset
    btn = 5'b11000;
    rst = 1'b0;
    wait_ticks(1);
    check_eq("diag1_s0x", sx(0), 12);
    check_eq("diag1_s0y", sy(0), 12);
    check_eq("auto1_s1x", sx(1), 76);
    check_eq("auto1_s1y", sy(1), 12);
    c = 0;
    while (!game_tick && c < 20) begin
      @(negedge clk);
      c++;
    end
    check_eq("tick_period", c + 1, 4);
    @(negedge clk);
    check_eq("diag2_s0x", sx(0), 14);
    check_eq("diag2_s0y", sy(0), 14);

    // Opposing pairs cancel on both axes
    btn = 5'b11110;
    wait_ticks(1);
    check_eq("cancel_s0x", sx(0), 14);
    check_eq("cancel_s0y", sy(0), 14);

    // x-/y- down to the lower bounds, then clamp
    btn = 5'b00110;
    wait_ticks(1);
    check_eq("dec1_s0x", sx(0), 12);
    check_eq("dec1_s0y", sy(0), 12);
    wait_ticks(1);
    check_eq("dec2_s0x", sx(0), 10);
    check_eq("dec2_s0y", sy(0), 10);
    wait_ticks(1);
    check_eq("clamp_s0x", sx(0), 10);
    check_eq("clamp_s0y", sy(0), 10);

    // Autonomous sprite reaching the far bounds from a fresh reset
    btn = 5'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(653);
    check_eq("edge_s1x", sx(1), 1380);
`ifdef SPRITE_WRAP_EN
    check_eq("edge_s1y", sy(1), 484);
`else
    check_eq("edge_s1y", sy(1), 366);
`endif
    wait_ticks(1);
`ifdef SPRITE_WRAP_EN
    check_eq("hit_s1x", sx(1), 10);
    check_eq("hit_s1y", sy(1), 486);
`else
    check_eq("hit_s1x", sx(1), 1380);
    check_eq("hit_s1y", sy(1), 364);
`endif
    wait_ticks(1);
`ifdef SPRITE_WRAP_EN
    check_eq("after_s1x", sx(1), 12);
    check_eq("after_s1y", sy(1), 488);
`else
    check_eq("after_s1x", sx(1), 1378);
    check_eq("after_s1y", sy(1), 362);
`endif
    check_eq("idle_s0x", sx(0), 10);
    check_eq("idle_s0y", sy(0), 10);

    // Respawn with a second pulse arriving while busy
    btn = 5'b00001;                 // sampled at edge k
    @(negedge clk);
    btn = 5'b0;
    check_eq("sp_busy_k", int'(spawn_busy), 0);
    @(negedge clk);
    btn = 5'b00001;                 // second pulse, sampled at k+2 and k+3
    check_eq("sp_busy_k1", int'(spawn_busy), 0);
    @(negedge clk);
    check_eq("sp_busy_k2", int'(spawn_busy), 0);
    @(negedge clk);
    btn = 5'b0;
    check_eq("sp_busy_k3", int'(spawn_busy), 1);
    check_eq("sp_done_k3", int'(spawn_done), 0);
    e0x = rpos(mlx[0], 10, 1380);
    e0y = rpos(mly[0], 10, 840);
    @(negedge clk);
    check_eq("sp_busy_k4", int'(spawn_busy), 1);
    e1x = rpos(mlx[1], 10, 1380);
    e1y = rpos(mly[1], 10, 840);
    @(negedge clk);
    check_eq("sp_busy_k5", int'(spawn_busy), 1);
    check_eq("sp_done_k5", int'(spawn_done), 1);
    check_eq("sp_s0x", sx(0), e0x);
    check_eq("sp_s0y", sy(0), e0y);
    check_eq("sp_s1x", sx(1), e1x);
    check_eq("sp_s1y", sy(1), e1y);
    check_eq("sp_rng_x", int'(sx(0) >= 10 && sx(0) <= 1380 && sx(1) >= 10 && sx(1) <= 1380), 1);
    check_eq("sp_rng_y", int'(sy(0) >= 10 && sy(0) <= 840 && sy(1) >= 10 && sy(1) <= 840), 1);
    @(negedge clk);
    check_eq("sp_busy_k6", int'(spawn_busy), 0);
    check_eq("sp_done_k6", int'(spawn_done), 0);
    nb = 0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (spawn_busy) nb++;
      if (spawn_done) nd++;
    end
    check_eq("sp_ignored_busy", nb, 0);
    check_eq("sp_ignored_done", nd, 0);

    // Asynchronous reset in the middle of a respawn
    btn = 5'b00001;
    @(negedge clk);
    btn = 5'b0;
    c = 0;
    while (!spawn_busy && c < 10) begin
      @(negedge clk);
      c++;
    end
    check_eq("rs_busy_seen", int'(spawn_busy), 1);
    #1 rst = 1'b1;
    #1;
    check_reset_vals("rs");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rs_tick1", int'(game_tick), 0);
    @(negedge clk);
    check_eq("rs_tick2", int'(game_tick), 0);
    @(negedge clk);
    check_eq("rs_tick3", int'(game_tick), 1);
    check_eq("rs_busy_after", int'(spawn_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
